// File: rtl/rob_param.sv
// rtl/rob_param.sv - parametrised reorder buffer with in-order commit and misprediction flush
//
// Purpose: tracks in-flight instructions between the issue queue (allocation)
// and the register file (in-order commit). Results arrive on NUM_CDB completion
// buses; branch and jalr outcomes are resolved when they reach the head.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_*                  entry allocation from the issue queue; alloc_tag is the tail entry
//   cdb_valid/tag/data       NUM_CDB packed completion buses, bus i at slice i
//   src_{a,b}_tag/ready/data operand lookup by tag
//   store_head, store_done   head-of-buffer store handshake with memory
//   commit_*                 in-order retirement (combinational from head state)
//   branch_complete, pc_flush, pc_target, flush  branch/jalr resolution to the front end
//
// Configuration macro: ROB_BYPASS_EN - when defined, operand lookups also see
// completions arriving on the CDB in the same cycle.

module rob_param #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 6,
  parameter int XLEN    = 32,
  localparam int TW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  output logic [TW-1:0]           alloc_tag,
  input  logic [4:0]              alloc_rd,
  input  logic [1:0]              alloc_kind,
  input  logic                    alloc_done,
  input  logic [XLEN-1:0]         alloc_data,
  input  logic [XLEN-1:0]         alloc_pred,
  input  logic [2:0]              alloc_pcsave,
  input  logic [NUM_CDB-1:0]      cdb_valid,
  input  logic [NUM_CDB*TW-1:0]   cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0] cdb_data,
  input  logic [TW-1:0]           src_a_tag,
  input  logic [TW-1:0]           src_b_tag,
  output logic                    src_a_ready,
  output logic                    src_b_ready,
  output logic [XLEN-1:0]         src_a_data,
  output logic [XLEN-1:0]         src_b_data,
  output logic                    store_head,
  input  logic                    store_done,
  output logic                    commit_valid,
  output logic                    commit_we,
  output logic [4:0]              commit_rd,
  output logic [XLEN-1:0]         commit_data,
  output logic [TW-1:0]           commit_tag,
  output logic                    branch_complete,
  output logic [2:0]              pc_flush,
  output logic [XLEN-1:0]         pc_target,
  output logic                    flush
);

  localparam logic [1:0]  KIND_REG  = 2'd0;
  localparam logic [1:0]  KIND_BR   = 2'd1;
  localparam logic [1:0]  KIND_ST   = 2'd2;
  localparam logic [1:0]  KIND_JALR = 2'd3;
  localparam logic [TW:0] FULL      = (TW+1)'(DEPTH);

  logic [TW-1:0]    head_q, head_d;
  logic [TW-1:0]    tail_q, tail_d;
  logic [TW:0]      count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;

  logic [4:0]       rd_q     [DEPTH];
  logic [1:0]       kind_q   [DEPTH];
  logic [XLEN-1:0]  data_q   [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [XLEN-1:0]  pred_q   [DEPTH];
  logic [2:0]       pcsave_q [DEPTH];

  // Per-entry CDB match. Buses are scanned from the highest index down so the
  // lowest-numbered matching bus is the last assignment and wins.
  logic [DEPTH-1:0] cdb_hit;
  logic [XLEN-1:0]  cdb_hit_data [DEPTH];
  logic [DEPTH-1:0] cdb_accept;

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      cdb_hit[e]      = 1'b0;
      cdb_hit_data[e] = '0;
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
        if (cdb_valid[i] && (cdb_tag[i*TW +: TW] == TW'(e))) begin
          cdb_hit[e]      = 1'b1;
          cdb_hit_data[e] = cdb_data[i*XLEN +: XLEN];
        end
      end
      // Stores complete only through the memory handshake, never from the CDB.
      cdb_accept[e] = cdb_hit[e] && busy_q[e] && !done_q[e] && (kind_q[e] != KIND_ST);
    end
  end

  // Head decode
  logic       head_live;
  logic [1:0] head_kind;
  logic       alloc_fire;
  logic       br_miss;
  logic       jalr_miss;

  assign head_live  = (count_q != '0) && busy_q[head_q];
  assign head_kind  = kind_q[head_q];
  assign store_head = head_live && (head_kind == KIND_ST);

  assign commit_valid = head_live &&
                        ((head_kind == KIND_ST) ? store_done : done_q[head_q]);

  assign br_miss   = (head_kind == KIND_BR)   && (data_q[head_q][0] != pred_q[head_q][0]);
  assign jalr_miss = (head_kind == KIND_JALR) && (target_q[head_q] != pred_q[head_q]);
  assign flush     = commit_valid && (br_miss || jalr_miss);

  assign commit_we       = commit_valid && ((head_kind == KIND_REG) || (head_kind == KIND_JALR));
  assign commit_rd       = commit_valid ? rd_q[head_q]   : '0;
  assign commit_data     = commit_valid ? data_q[head_q] : '0;
  assign commit_tag      = commit_valid ? head_q         : '0;
  assign branch_complete = commit_valid && ((head_kind == KIND_BR) || (head_kind == KIND_JALR));
  assign pc_flush        = branch_complete ? pcsave_q[head_q] : '0;
  assign pc_target       = !branch_complete         ? '0 :
                           (head_kind == KIND_JALR) ? target_q[head_q] : data_q[head_q];

  // The full check uses only registered count, so a full buffer never
  // allocates even if the head commits in the same cycle.
  assign alloc_ready = (count_q != FULL) && !flush;
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      done_d  = '0;
    end else begin
      done_d = done_q | cdb_accept;
      if (commit_valid) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
      end
      // Applied last so a fresh allocation overrides any CDB strobe to that entry.
      if (alloc_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = alloc_done;
        tail_d         = tail_q + 1'b1;
      end
      case ({alloc_fire, commit_valid})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Payload storage needs no reset: every consumer is qualified by busy/done.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (alloc_fire && (tail_q == TW'(e))) begin
        rd_q[e]     <= alloc_rd;
        kind_q[e]   <= alloc_kind;
        data_q[e]   <= alloc_data;
        target_q[e] <= '0;
        pred_q[e]   <= alloc_pred;
        pcsave_q[e] <= alloc_pcsave;
      end else if (cdb_accept[e] && !flush) begin
        // A jalr keeps its link in data; the bus carries the resolved target.
        if (kind_q[e] == KIND_JALR) begin
          target_q[e] <= cdb_hit_data[e];
        end else begin
          data_q[e] <= cdb_hit_data[e];
        end
      end
    end
  end

  // Operand lookup: returns {ready, data}; data is zero when not ready.
  function automatic logic [XLEN:0] lookup(input logic [TW-1:0] t);
    logic           rdy;
    logic [XLEN-1:0] val;
    rdy = busy_q[t] && done_q[t];
    val = rdy ? data_q[t] : '0;
`ifdef ROB_BYPASS_EN
    // Only kinds whose CDB result lands in data may forward it.
    if (busy_q[t] && !done_q[t] && cdb_hit[t] &&
        ((kind_q[t] == KIND_REG) || (kind_q[t] == KIND_BR))) begin
      rdy = 1'b1;
      val = cdb_hit_data[t];
    end
`endif
    return {rdy, val};
  endfunction

  always_comb begin
    {src_a_ready, src_a_data} = lookup(src_a_tag);
    {src_b_ready, src_b_data} = lookup(src_b_tag);
  end

endmodule

// File: tb/tb_rob_param.sv
// tb/tb_rob_param.sv - directed self-checking bench for rob_param (DEPTH=8, NUM_CDB=6, XLEN=32)

module tb_rob_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_valid;
  logic         alloc_ready;
  logic [2:0]   alloc_tag;
  logic [4:0]   alloc_rd;
  logic [1:0]   alloc_kind;
  logic         alloc_done;
  logic [31:0]  alloc_data;
  logic [31:0]  alloc_pred;
  logic [2:0]   alloc_pcsave;
  logic [5:0]   cdb_valid;
  logic [17:0]  cdb_tag;
  logic [191:0] cdb_data;
  logic [2:0]   src_a_tag;
  logic [2:0]   src_b_tag;
  logic         src_a_ready;
  logic         src_b_ready;
  logic [31:0]  src_a_data;
  logic [31:0]  src_b_data;
  logic         store_head;
  logic         store_done;
  logic         commit_valid;
  logic         commit_we;
  logic [4:0]   commit_rd;
  logic [31:0]  commit_data;
  logic [2:0]   commit_tag;
  logic         branch_complete;
  logic [2:0]   pc_flush;
  logic [31:0]  pc_target;
  logic         flush;

  int checks   = 0;
  int failures = 0;

  rob_param #(.DEPTH(8), .NUM_CDB(6), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_rd(alloc_rd), .alloc_kind(alloc_kind), .alloc_done(alloc_done),
    .alloc_data(alloc_data), .alloc_pred(alloc_pred), .alloc_pcsave(alloc_pcsave),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .src_a_tag(src_a_tag), .src_b_tag(src_b_tag),
    .src_a_ready(src_a_ready), .src_b_ready(src_b_ready),
    .src_a_data(src_a_data), .src_b_data(src_b_data),
    .store_head(store_head), .store_done(store_done),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .branch_complete(branch_complete), .pc_flush(pc_flush), .pc_target(pc_target),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb_set(input int bus, input int tag, input logic [31:0] d);
    cdb_valid[bus]          = 1'b1;
    cdb_tag[bus*3 +: 3]     = 3'(tag);
    cdb_data[bus*32 +: 32]  = d;
  endtask

  task automatic cdb_clr();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  task automatic alloc_set(input logic [1:0] kind, input logic [4:0] rd, input logic done,
                           input logic [31:0] data, input logic [31:0] pred, input logic [2:0] ps);
    alloc_valid  = 1'b1;
    alloc_kind   = kind;
    alloc_rd     = rd;
    alloc_done   = done;
    alloc_data   = data;
    alloc_pred   = pred;
    alloc_pcsave = ps;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_rd = '0; alloc_kind = '0; alloc_done = 1'b0;
    alloc_data = '0; alloc_pred = '0; alloc_pcsave = '0;
    cdb_clr();
    src_a_tag = '0; src_b_tag = '0; store_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_store_head", 32'(store_head), 32'd0);
    chk("rst_src_a_ready", 32'(src_a_ready), 32'd0);
    chk("rst_src_a_data", src_a_data, 32'd0);
    chk("rst_branch_complete", 32'(branch_complete), 32'd0);

    // Fill all 8 entries with reg-writers rd=1..8
    for (int i = 0; i < 8; i++) begin
      alloc_set(2'd0, 5'(i + 1), 1'b0, 32'd0, 32'd0, 3'd0);
      #1;
      chk("fill_tag", 32'(alloc_tag), 32'(i));
      chk("fill_ready", 32'(alloc_ready), 32'd1);
      step();
    end
    alloc_valid = 1'b0;
    #1;
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_no_commit", 32'(commit_valid), 32'd0);

    // Complete tag 0 -> commits next cycle
    cdb_set(0, 0, 32'hA5);
    step();
    cdb_clr();
    #1;
    chk("c0_valid", 32'(commit_valid), 32'd1);
    chk("c0_rd", 32'(commit_rd), 32'd1);
    chk("c0_data", commit_data, 32'hA5);
    chk("c0_tag", 32'(commit_tag), 32'd0);
    chk("c0_we", 32'(commit_we), 32'd1);
    chk("c0_ready_while_full", 32'(alloc_ready), 32'd0);
    step();
    chk("after_c0_ready", 32'(alloc_ready), 32'd1);
    chk("after_c0_tag", 32'(alloc_tag), 32'd0);
    chk("after_c0_no_commit", 32'(commit_valid), 32'd0);

    // Out-of-order completion: tag3, then tag2, then tag1; commits stay in order
    cdb_set(0, 3, 32'h33);
    step();
    cdb_clr();
    #1;
    chk("ooo_hold_a", 32'(commit_valid), 32'd0);
    cdb_set(0, 2, 32'h22);
    step();
    cdb_clr();
    #1;
    chk("ooo_hold_b", 32'(commit_valid), 32'd0);
    cdb_set(1, 3, 32'hEE);   // already done: ignored
    cdb_set(2, 1, 32'h11);   // lowest bus for tag1 wins
    cdb_set(4, 1, 32'h99);
    step();
    cdb_clr();
    #1;
    chk("ooo_c1_valid", 32'(commit_valid), 32'd1);
    chk("ooo_c1_tag", 32'(commit_tag), 32'd1);
    chk("ooo_c1_rd", 32'(commit_rd), 32'd2);
    chk("ooo_c1_data", commit_data, 32'h11);
    step();
    chk("ooo_c2_tag", 32'(commit_tag), 32'd2);
    chk("ooo_c2_data", commit_data, 32'h22);
    step();
    chk("ooo_c3_tag", 32'(commit_tag), 32'd3);
    chk("ooo_c3_rd", 32'(commit_rd), 32'd4);
    chk("ooo_c3_data", commit_data, 32'h33);
    step();
    chk("ooo_c4_pending", 32'(commit_valid), 32'd0);

    // Restart clean
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Mispredicted branch: pred taken, outcome not taken
    alloc_set(2'd1, 5'd0, 1'b0, 32'd0, 32'd1, 3'd5);
    step();
    alloc_valid = 1'b0;
    cdb_set(0, 0, 32'd0);
    step();
    cdb_clr();
    alloc_set(2'd0, 5'd9, 1'b1, 32'h77, 32'd0, 3'd0);  // dropped by flush
    #1;
    chk("br_commit", 32'(commit_valid), 32'd1);
    chk("br_complete", 32'(branch_complete), 32'd1);
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_target", pc_target, 32'd0);
    chk("br_pc_flush", 32'(pc_flush), 32'd5);
    chk("br_we", 32'(commit_we), 32'd0);
    chk("br_alloc_ready_forced", 32'(alloc_ready), 32'd0);
    step();
    alloc_valid = 1'b0;
    src_a_tag = 3'd0;
    #1;
    chk("post_flush_tag", 32'(alloc_tag), 32'd0);
    chk("post_flush_ready", 32'(alloc_ready), 32'd1);
    chk("post_flush_commit", 32'(commit_valid), 32'd0);
    chk("post_flush_dropped", 32'(src_a_ready), 32'd0);

    // Correctly predicted branch, allocated already done
    alloc_set(2'd1, 5'd0, 1'b1, 32'd0, 32'd0, 3'd2);
    step();
    alloc_valid = 1'b0;
    #1;
    chk("brok_commit", 32'(commit_valid), 32'd1);
    chk("brok_complete", 32'(branch_complete), 32'd1);
    chk("brok_flush", 32'(flush), 32'd0);
    chk("brok_pc_flush", 32'(pc_flush), 32'd2);
    step();

    // Jalr predicted correctly (tag1)
    alloc_set(2'd3, 5'd1, 1'b0, 32'h104, 32'h200, 3'd3);
    step();
    alloc_valid = 1'b0;
    src_a_tag = 3'd1;
    #1;
    chk("jalr_src_not_ready", 32'(src_a_ready), 32'd0);
    cdb_set(0, 1, 32'h200);
    step();
    cdb_clr();
    #1;
    chk("jalr_commit", 32'(commit_valid), 32'd1);
    chk("jalr_we", 32'(commit_we), 32'd1);
    chk("jalr_rd", 32'(commit_rd), 32'd1);
    chk("jalr_data", commit_data, 32'h104);
    chk("jalr_target", pc_target, 32'h200);
    chk("jalr_flush", 32'(flush), 32'd0);
    chk("jalr_src_link", src_a_data, 32'h104);
    step();

    // Jalr mispredicted (tag2)
    alloc_set(2'd3, 5'd1, 1'b0, 32'h104, 32'h200, 3'd4);
    step();
    alloc_valid = 1'b0;
    cdb_set(0, 2, 32'h204);
    step();
    cdb_clr();
    #1;
    chk("jalr2_commit", 32'(commit_valid), 32'd1);
    chk("jalr2_flush", 32'(flush), 32'd1);
    chk("jalr2_target", pc_target, 32'h204);
    chk("jalr2_data", commit_data, 32'h104);
    step();

    // Store at head (tag0 after flush)
    alloc_set(2'd2, 5'd0, 1'b0, 32'd0, 32'd0, 3'd0);
    step();
    alloc_valid = 1'b0;
    #1;
    chk("st_head", 32'(store_head), 32'd1);
    chk("st_hold", 32'(commit_valid), 32'd0);
    cdb_set(0, 0, 32'h123);
    step();
    cdb_clr();
    #1;
    chk("st_cdb_ignored", 32'(commit_valid), 32'd0);
    chk("st_head_still", 32'(store_head), 32'd1);
    store_done = 1'b1;
    #1;
    chk("st_commit", 32'(commit_valid), 32'd1);
    chk("st_we", 32'(commit_we), 32'd0);
    chk("st_tag", 32'(commit_tag), 32'd0);
    step();
    store_done = 1'b0;
    #1;
    chk("st_gone", 32'(store_head), 32'd0);
    chk("st_no_commit", 32'(commit_valid), 32'd0);

    // Bypass: reg-writers at tags 1,2,3 (rd 5,6,7)
    for (int i = 0; i < 3; i++) begin
      alloc_set(2'd0, 5'(i + 5), 1'b0, 32'd0, 32'd0, 3'd0);
      #1;
      chk("byp_alloc_tag", 32'(alloc_tag), 32'(i + 1));
      step();
    end
    alloc_valid = 1'b0;
    src_a_tag = 3'd2;
    src_b_tag = 3'd1;
    cdb_set(3, 2, 32'h55);
    #1;
`ifdef ROB_BYPASS_EN
    chk("byp_same_ready", 32'(src_a_ready), 32'd1);
    chk("byp_same_data", src_a_data, 32'h55);
`else
    chk("byp_same_ready", 32'(src_a_ready), 32'd0);
    chk("byp_same_data", src_a_data, 32'd0);
`endif
    chk("byp_other_ready", 32'(src_b_ready), 32'd0);
    chk("byp_other_data", src_b_data, 32'd0);
    step();
    cdb_clr();
    #1;
    chk("byp_next_ready", 32'(src_a_ready), 32'd1);
    chk("byp_next_data", src_a_data, 32'h55);
    chk("byp_no_commit", 32'(commit_valid), 32'd0);
    cdb_set(5, 1, 32'h66);
    step();
    cdb_clr();
    #1;
    chk("tail_c1_tag", 32'(commit_tag), 32'd1);
    chk("tail_c1_rd", 32'(commit_rd), 32'd5);
    chk("tail_c1_data", commit_data, 32'h66);
    step();
    chk("tail_c2_tag", 32'(commit_tag), 32'd2);
    chk("tail_c2_data", commit_data, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
